// File: rtl/comb_perm_engine.sv
// Iterative nCr / nPr engine: multiply by one factor per step, then exact restoring divide for nCr.
// Latency 2 + k*(1+D) cycles from accepted start to done; start is sampled only when idle.
module comb_perm_engine #(
    parameter int N_W   = 4,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [N_W-1:0]   n,
    input  logic [N_W-1:0]   m,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] result,
    output logic             ovf,
    output logic             err
);

    localparam int P_W = OUT_W + N_W;
    localparam int C_W = $clog2(P_W + 1);
    localparam logic [C_W-1:0] DIV_LAST = C_W'(P_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_MUL,
        S_DIV,
        S_FIN
    } state_t;

    state_t           state_q;
    logic [N_W-1:0]   n_q, m_q, k_q, i_q, rem_q;
    logic             mode_q;
    logic [OUT_W-1:0] r_q;
    logic [P_W-1:0]   quot_q;
    logic [C_W-1:0]   cnt_q;

    logic [N_W-1:0]   diff_d, k_d, f_d, rem_d;
    logic [P_W-1:0]   prod_d, quot_d, step_val_d;
    logic [N_W:0]     rem_sh_d;
    logic             sub_ok_d, step_ovf_d, step_fire_d;

    always_comb begin
        diff_d      = n_q - m_q;
        k_d         = mode_q ? m_q : ((m_q < diff_d) ? m_q : diff_d);
        f_d         = mode_q ? (n_q - i_q + N_W'(1)) : (n_q - k_q + i_q);
        prod_d      = P_W'(r_q) * P_W'(f_d);
        rem_sh_d    = {rem_q, quot_q[P_W-1]};
        sub_ok_d    = rem_sh_d >= {1'b0, i_q};
        rem_d       = sub_ok_d ? N_W'(rem_sh_d - {1'b0, i_q}) : rem_sh_d[N_W-1:0];
        quot_d      = {quot_q[P_W-2:0], sub_ok_d};
        step_val_d  = (state_q == S_MUL) ? prod_d : quot_d;
        step_ovf_d  = |step_val_d[P_W-1:OUT_W];
        step_fire_d = ((state_q == S_MUL) && mode_q) ||
                      ((state_q == S_DIV) && (cnt_q == DIV_LAST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            m_q     <= '0;
            k_q     <= '0;
            i_q     <= '0;
            rem_q   <= '0;
            mode_q  <= 1'b0;
            r_q     <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q     <= n;
                        m_q     <= m;
                        mode_q  <= mode;
                        ovf     <= 1'b0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    k_q <= k_d;
                    i_q <= N_W'(1);
                    r_q <= OUT_W'(1);
                    if (m_q > n_q) begin
                        err     <= 1'b1;
                        r_q     <= '0;
                        state_q <= S_FIN;
                    end else if (k_d == '0) begin
                        state_q <= S_FIN;
                    end else begin
                        state_q <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (!mode_q) begin
                        quot_q  <= prod_d;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    cnt_q  <= cnt_q + C_W'(1);
                end
                S_FIN: begin
                    result  <= ovf ? '1 : r_q;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // Running value never decreases, so the first step that spills past OUT_W ends the op.
            if (step_fire_d) begin
                r_q <= step_val_d[OUT_W-1:0];
                if (step_ovf_d) begin
                    ovf     <= 1'b1;
                    state_q <= S_FIN;
                end else if (i_q == k_q) begin
                    state_q <= S_FIN;
                end else begin
                    i_q     <= i_q + N_W'(1);
                    state_q <= S_MUL;
                end
            end
        end
    end

endmodule
